// File: rtl/life_run_controller.sv
`default_nettype none
// ============================================================================
// Module   : life_run_controller
// Brief    : Single-clock Game of Life sequencer: button debounce, mode FSM,
//            generation tick, engine handshake, row cursor, generation count.
// Revision : 1.0 - initial release
// ============================================================================
module life_run_controller #(
    parameter int TICK_DIV        = 50_000_000,
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int ROWS            = 16,
    parameter int GEN_W           = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    btn_l,
    input  logic                    btn_r,
    input  logic                    btn_u,
    input  logic                    btn_d,
    input  logic                    btn_c,
    input  logic [1:0]              speed_sel,
    input  logic                    gen_done,
    output logic [2:0]              mode,
    output logic                    gen_req,
    output logic                    board_latch,
    output logic [$clog2(ROWS)-1:0] row_sel,
    output logic                    row_load,
    output logic                    clear_board,
    output logic [GEN_W-1:0]        gen_cnt
);

    localparam int c_db_w = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int c_tw   = $clog2(TICK_DIV + 1);
    localparam int c_rw   = $clog2(ROWS);

    localparam logic [c_db_w-1:0] c_db_last  = c_db_w'(DEBOUNCE_CYCLES - 1);
    localparam logic [c_tw-1:0]   c_tick_div = c_tw'(TICK_DIV);
    localparam logic [c_rw-1:0]   c_row_max  = c_rw'(ROWS - 1);

    localparam logic [2:0] c_mode_set   = 3'b001;
    localparam logic [2:0] c_mode_run   = 3'b010;
    localparam logic [2:0] c_mode_pause = 3'b100;

    typedef enum logic [1:0] {
        ST_SET   = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_BUSY  = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // Button conditioning: bit order {c, d, u, r, l}
    // ------------------------------------------------------------------
    logic [4:0] w_btn_raw;
    logic [4:0] w_press;

    assign w_btn_raw = {btn_c, btn_d, btn_u, btn_r, btn_l};

    for (genvar i = 0; i < 5; i++) begin : g_btn
        logic              r_sync1;
        logic              r_sync2;
        logic              r_level;
        logic [c_db_w-1:0] r_cnt;

        always_ff @(posedge clk) begin
            if (!reset) begin
                r_sync1 <= 1'b0;
                r_sync2 <= 1'b0;
                r_level <= 1'b0;
                r_cnt   <= '0;
            end else begin
                r_sync1 <= w_btn_raw[i];
                r_sync2 <= r_sync1;
                if (r_sync2 == r_level) begin
                    r_cnt <= '0;
                end else if (r_cnt == c_db_last) begin
                    r_cnt   <= '0;
                    r_level <= r_sync2;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end

        // Press is the cycle the debounced level is about to rise.
        assign w_press[i] = r_sync2 && !r_level && (r_cnt == c_db_last);
    end

    logic w_l, w_r, w_u, w_d, w_c;
    assign {w_c, w_d, w_u, w_r, w_l} = w_press;

    // ------------------------------------------------------------------
    // Mode FSM and datapath registers
    // ------------------------------------------------------------------
    state_t             r_state, w_state_n;
    logic               r_ret_pause, w_ret_pause_n;
    logic               r_stop_pending, w_stop_n;
    logic [c_tw-1:0]    r_tick, w_tick_n;
    logic [c_rw-1:0]    r_row_sel, w_row_n;
    logic [GEN_W-1:0]   r_gen_cnt, w_cnt_n;
    logic               r_gen_req, w_req_n;
    logic               r_board_latch, w_latch_n;
    logic               r_row_load, w_load_n;
    logic               r_clear, w_clear_n;
    logic [2:0]         r_mode, w_mode_n;
    logic [c_tw-1:0]    w_period;
    logic               w_tick_hit;

    assign w_period   = c_tick_div >> speed_sel;
    // ">=" lets a shortened period fire at once when the count already overshoots.
    assign w_tick_hit = (r_tick + 1'b1) >= w_period;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state        <= ST_SET;
            r_ret_pause    <= 1'b0;
            r_stop_pending <= 1'b0;
            r_tick         <= '0;
            r_row_sel      <= '0;
            r_gen_cnt      <= '0;
            r_gen_req      <= 1'b0;
            r_board_latch  <= 1'b0;
            r_row_load     <= 1'b0;
            r_clear        <= 1'b0;
            r_mode         <= c_mode_set;
        end else begin
            r_state        <= w_state_n;
            r_ret_pause    <= w_ret_pause_n;
            r_stop_pending <= w_stop_n;
            r_tick         <= w_tick_n;
            r_row_sel      <= w_row_n;
            r_gen_cnt      <= w_cnt_n;
            r_gen_req      <= w_req_n;
            r_board_latch  <= w_latch_n;
            r_row_load     <= w_load_n;
            r_clear        <= w_clear_n;
            r_mode         <= w_mode_n;
        end
    end

    always_comb begin
        w_state_n     = r_state;
        w_ret_pause_n = r_ret_pause;
        w_stop_n      = r_stop_pending;
        w_tick_n      = r_tick;
        w_row_n       = r_row_sel;
        w_cnt_n       = r_gen_cnt;
        w_req_n       = r_gen_req;
        w_latch_n     = 1'b0;
        w_load_n      = 1'b0;
        w_clear_n     = 1'b0;
        w_mode_n      = c_mode_set;

        if (w_l) begin
            w_clear_n     = 1'b1;
            w_cnt_n       = '0;
            w_row_n       = '0;
            w_state_n     = ST_SET;
            w_req_n       = 1'b0;
            w_stop_n      = 1'b0;
            w_ret_pause_n = 1'b0;
            w_tick_n      = '0;
        end else begin
            case (r_state)
                ST_SET: begin
                    if (w_r) begin
                        w_state_n = ST_RUN;
                        w_tick_n  = '0;
                    end else if (w_c) begin
                        w_load_n = 1'b1;
                    end else if (w_u && !w_d) begin
                        w_row_n = (r_row_sel == c_row_max) ? '0 : r_row_sel + 1'b1;
                    end else if (w_d && !w_u) begin
                        w_row_n = (r_row_sel == '0) ? c_row_max : r_row_sel - 1'b1;
                    end
                end
                ST_RUN: begin
                    if (w_r) begin
                        w_state_n = ST_PAUSE;
                    end else if (w_tick_hit) begin
                        w_tick_n      = '0;
                        w_state_n     = ST_BUSY;
                        w_ret_pause_n = 1'b0;
                        w_req_n       = 1'b1;
                    end else begin
                        w_tick_n = r_tick + 1'b1;
                    end
                end
                ST_PAUSE: begin
                    if (w_r) begin
                        w_state_n = ST_RUN;
                    end else if (w_c) begin
                        w_state_n     = ST_BUSY;
                        w_ret_pause_n = 1'b1;
                        w_req_n       = 1'b1;
                    end
                end
                ST_BUSY: begin
                    if (w_r) begin
                        w_stop_n = 1'b1;
                    end
                    if (gen_done) begin
                        w_req_n   = 1'b0;
                        w_latch_n = 1'b1;
                        w_stop_n  = 1'b0;
                        if (r_gen_cnt != {GEN_W{1'b1}}) begin
                            w_cnt_n = r_gen_cnt + 1'b1;
                        end
                        w_state_n = (w_r || r_stop_pending || r_ret_pause) ? ST_PAUSE : ST_RUN;
                    end
                end
                default: w_state_n = ST_SET;
            endcase
        end

        case (w_state_n)
            ST_SET:   w_mode_n = c_mode_set;
            ST_RUN:   w_mode_n = c_mode_run;
            ST_PAUSE: w_mode_n = c_mode_pause;
            default:  w_mode_n = w_ret_pause_n ? c_mode_pause : c_mode_run;
        endcase
    end

    assign mode        = r_mode;
    assign gen_req     = r_gen_req;
    assign board_latch = r_board_latch;
    assign row_sel     = r_row_sel;
    assign row_load    = r_row_load;
    assign clear_board = r_clear;
    assign gen_cnt     = r_gen_cnt;

endmodule
`default_nettype wire

// File: tb/tb_life_run_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_life_run_controller
// Brief    : Self-checking bench for life_run_controller (vector table,
//            generation scoreboard, hand-written multi-cycle sequences).
// Revision : 1.0 - initial release
// ============================================================================
module tb_life_run_controller;

    localparam int TICK_DIV        = 16;
    localparam int DEBOUNCE_CYCLES = 4;
    localparam int ROWS            = 16;
    localparam int GEN_W           = 16;

    localparam logic [4:0] B_L = 5'b00001;
    localparam logic [4:0] B_R = 5'b00010;
    localparam logic [4:0] B_U = 5'b00100;
    localparam logic [4:0] B_D = 5'b01000;
    localparam logic [4:0] B_C = 5'b10000;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [4:0]  btn = 5'b0;
    logic [1:0]  speed_sel = 2'd0;
    logic        gen_done = 1'b0;

    logic [2:0]  mode, s_mode;
    logic        gen_req, board_latch, row_load, clear_board;
    logic        s_gen_req, s_board_latch, s_row_load, s_clear_board;
    logic [3:0]  row_sel, s_row_sel;
    logic [15:0] gen_cnt;
    logic [1:0]  s_gen_cnt;

    always #5 clk = ~clk;

    life_run_controller #(
        .TICK_DIV(TICK_DIV), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .ROWS(ROWS), .GEN_W(GEN_W)
    ) dut (
        .clk(clk), .reset(reset),
        .btn_l(btn[0]), .btn_r(btn[1]), .btn_u(btn[2]), .btn_d(btn[3]), .btn_c(btn[4]),
        .speed_sel(speed_sel), .gen_done(gen_done),
        .mode(mode), .gen_req(gen_req), .board_latch(board_latch),
        .row_sel(row_sel), .row_load(row_load), .clear_board(clear_board), .gen_cnt(gen_cnt)
    );

    // Same stimulus, 2-bit counter: exercises saturation within a few generations.
    life_run_controller #(
        .TICK_DIV(TICK_DIV), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .ROWS(ROWS), .GEN_W(2)
    ) dut_sat (
        .clk(clk), .reset(reset),
        .btn_l(btn[0]), .btn_r(btn[1]), .btn_u(btn[2]), .btn_d(btn[3]), .btn_c(btn[4]),
        .speed_sel(speed_sel), .gen_done(gen_done),
        .mode(s_mode), .gen_req(s_gen_req), .board_latch(s_board_latch),
        .row_sel(s_row_sel), .row_load(s_row_load), .clear_board(s_clear_board), .gen_cnt(s_gen_cnt)
    );

    typedef struct {
        logic [15:0] cnt;
        logic [1:0]  sat;
    } sb_t;

    typedef struct {
        string      name;
        logic [4:0] btn;
        logic [3:0] row;
        int         loads;
    } vec_t;

    int          checks = 0;
    int          errors = 0;
    sb_t         sb_q[$];
    logic [15:0] model_cnt = 16'd0;
    bit          eng_en = 1'b1;
    bit          eng_busy = 1'b0;
    int          eng_delay = 3;
    int          eng_wait = 0;
    vec_t        vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name, input int act, input int exp);
        checks++;
        errors++;
        $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // One clock: scoreboard on board_latch, then the engine model answers gen_req.
    task automatic step();
        sb_t e;
        @(negedge clk);
        if (board_latch) begin
            if (sb_q.size() == 0) begin
                fail_now("latch_unexpected", 1, 0);
            end else begin
                e = sb_q.pop_front();
                check("gen_cnt", {16'b0, gen_cnt}, {16'b0, e.cnt});
                check("gen_cnt_sat", {30'b0, s_gen_cnt}, {30'b0, e.sat});
            end
        end
        gen_done = 1'b0;
        if (eng_busy) begin
            eng_wait--;
            if (eng_wait == 0) begin
                gen_done = 1'b1;
                eng_busy = 1'b0;
                if (model_cnt != 16'hFFFF) model_cnt++;
                e.cnt = model_cnt;
                e.sat = (model_cnt > 16'd3) ? 2'd3 : model_cnt[1:0];
                sb_q.push_back(e);
            end
        end else if (eng_en && gen_req) begin
            eng_busy = 1'b1;
            eng_wait = eng_delay - 1;
        end
    endtask

    task automatic wait_req(input logic lvl, output int n);
        n = 0;
        while (gen_req !== lvl && n < 100) begin
            step();
            n++;
        end
        if (gen_req !== lvl) fail_now("req_timeout", n, 100);
    endtask

    task automatic press(input logic [4:0] mask);
        btn = mask;
        repeat (8) step();
        btn = 5'b0;
        repeat (8) step();
    endtask

    initial begin
        int n1, n2, k, loads, rises, highs, bad_mode;
        logic [3:0] load_row;

        vecs[0] = '{"d_once",   B_D,       4'd0,  0};
        vecs[1] = '{"d_wrap",   B_D,       4'd15, 0};
        vecs[2] = '{"u_wrap",   B_U,       4'd0,  0};
        vecs[3] = '{"u_again",  B_U,       4'd1,  0};
        vecs[4] = '{"c_load",   B_C,       4'd1,  1};
        vecs[5] = '{"u_and_d",  B_U | B_D, 4'd1,  0};

        // Reset
        repeat (3) step();
        check("rst_mode", {29'b0, mode}, 32'h1);
        check("rst_gen_cnt", {16'b0, gen_cnt}, 32'h0);
        check("rst_row_sel", {28'b0, row_sel}, 32'h0);
        check("rst_strobes", {28'b0, gen_req, board_latch, row_load, clear_board}, 32'h0);
        reset = 1'b1;
        step();
        check("post_rst_mode", {29'b0, mode}, 32'h1);

        // Glitch shorter than the debounce window is rejected
        btn = B_U;
        repeat (3) step();
        btn = 5'b0;
        repeat (10) step();
        check("glitch_row_sel", {28'b0, row_sel}, 32'h0);

        // Held press acts exactly 6 cycles after assertion
        btn = B_U;
        repeat (5) step();
        check("press_lat_early", {28'b0, row_sel}, 32'h0);
        step();
        check("press_lat_row_sel", {28'b0, row_sel}, 32'h1);
        repeat (4) step();
        btn = 5'b0;
        repeat (10) step();
        check("release_no_pulse", {28'b0, row_sel}, 32'h1);

        // Cursor / load vector table in SET
        foreach (vecs[i]) begin
            loads = 0;
            load_row = 4'hx;
            btn = vecs[i].btn;
            for (int c = 0; c < 16; c++) begin
                if (c == 8) btn = 5'b0;
                step();
                if (row_load) begin
                    loads++;
                    load_row = row_sel;
                end
            end
            check({vecs[i].name, "_row"}, {28'b0, row_sel}, {28'b0, vecs[i].row});
            check({vecs[i].name, "_loads"}, loads, vecs[i].loads);
            if (vecs[i].loads > 0) check({vecs[i].name, "_load_row"}, {28'b0, load_row}, {28'b0, vecs[i].row});
        end

        // RUN: first request 16 cycles after entering RUN
        btn = B_R;
        repeat (6) step();
        check("run_mode", {29'b0, mode}, 32'h2);
        btn = 5'b0;
        wait_req(1'b1, k);
        check("first_req_delay", k, 16);

        wait_req(1'b0, n1);
        wait_req(1'b1, n2);
        check("period_div16", n1 + n2, 19);
        speed_sel = 2'd2;
        wait_req(1'b0, n1);
        wait_req(1'b1, n2);
        check("period_div4_a", n1 + n2, 7);
        wait_req(1'b0, n1);
        wait_req(1'b1, n2);
        check("period_div4_b", n1 + n2, 7);

        // R during BUSY: finish the generation, then PAUSE
        eng_delay = 10;
        wait_req(1'b0, n1);
        wait_req(1'b1, n2);
        btn = B_R;
        repeat (6) step();
        check("busy_mode", {29'b0, mode}, 32'h2);
        check("busy_req", {31'b0, gen_req}, 32'h1);
        btn = 5'b0;
        wait_req(1'b0, n1);
        check("stop_done_delay", n1, 4);
        check("stop_mode", {29'b0, mode}, 32'h4);
        rises = 0;
        for (int c = 0; c < 30; c++) begin
            step();
            if (gen_req) rises++;
        end
        check("pause_no_req", rises, 0);

        // Single step from PAUSE
        eng_delay = 3;
        rises = 0;
        highs = 0;
        bad_mode = 0;
        n1 = 0;
        btn = B_C;
        for (int c = 0; c < 30; c++) begin
            if (c == 8) btn = 5'b0;
            step();
            if (gen_req && !n1[0]) rises++;
            if (gen_req) highs++;
            n1 = {31'b0, gen_req};
            if (mode != 3'b100) bad_mode++;
        end
        check("step_req_count", rises, 1);
        check("step_req_cycles", highs, 3);
        check("step_mode_kept", bad_mode, 0);

        // L while BUSY; a late gen_done must be ignored
        eng_en = 1'b0;
        btn = B_R;
        repeat (6) step();
        check("resume_mode", {29'b0, mode}, 32'h2);
        btn = 5'b0;
        wait_req(1'b1, k);
        btn = B_L;
        model_cnt = 16'd0;
        repeat (6) step();
        check("clr_strobe", {31'b0, clear_board}, 32'h1);
        check("clr_req", {31'b0, gen_req}, 32'h0);
        check("clr_mode", {29'b0, mode}, 32'h1);
        check("clr_gen_cnt", {16'b0, gen_cnt}, 32'h0);
        check("clr_sat_mode", {29'b0, s_mode}, 32'h1);
        step();
        check("clr_strobe_width", {31'b0, clear_board}, 32'h0);
        btn = 5'b0;
        gen_done = 1'b1;
        step();
        check("late_done_latch", {31'b0, board_latch}, 32'h0);
        check("late_done_cnt", {16'b0, gen_cnt}, 32'h0);
        repeat (8) step();

        // Reset in the middle of BUSY
        press(B_U);
        eng_en = 1'b1;
        btn = B_R;
        repeat (6) step();
        btn = 5'b0;
        wait_req(1'b1, k);
        wait_req(1'b0, k);
        eng_en = 1'b0;
        wait_req(1'b1, k);
        check("pre_rst_busy_mode", {29'b0, mode}, 32'h2);
        reset = 1'b0;
        step();
        check("mid_rst_mode", {29'b0, mode}, 32'h1);
        check("mid_rst_gen_cnt", {16'b0, gen_cnt}, 32'h0);
        check("mid_rst_row_sel", {28'b0, row_sel}, 32'h0);
        check("mid_rst_strobes", {28'b0, gen_req, board_latch, row_load, clear_board}, 32'h0);
        check("mid_rst_sat_outs", {25'b0, s_gen_req, s_board_latch, s_row_load, s_clear_board, s_row_sel, s_gen_cnt == 2'd0},
              32'h1);
        model_cnt = 16'd0;
        eng_busy = 1'b0;
        reset = 1'b1;
        repeat (3) step();
        check("post_mid_rst_mode", {29'b0, mode}, 32'h1);
        check("scoreboard_empty", sb_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
